// File: rtl/hyperbus_ctrl.sv
// hyperbus_ctrl: single-word HyperBus read/write sequencer feeding an
// SDR-abstracted PHY (one 16-bit byte pair per hbus_clk). Builds the 48-bit
// command-address, waits out initial latency, moves one word, then holds
// CS# high for the recovery gap before accepting the next request.
module hyperbus_ctrl #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int LATENCY         = 6,
    parameter int FIXED_LATENCY   = 1,
    parameter int TCSHI           = 2,
    parameter int RD_TIMEOUT      = 64
) (
    input  logic                       hbus_clk,
    input  logic                       hbus_rst,
    input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    input  logic [1:0]                 hbus_mask_i,
    input  logic                       hbus_rrq,
    input  logic                       hbus_wrq,
    output logic                       hbus_ready,
    output logic                       hbus_valid,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    output logic                       hbus_err,
    output logic                       phy_cs_n,
    output logic                       phy_ck_en,
    output logic [15:0]                phy_dq_o,
    output logic                       phy_dq_oe,
    output logic [1:0]                 phy_rwds_o,
    output logic                       phy_rwds_oe,
    input  logic [15:0]                phy_dq_i,
    input  logic                       phy_rwds_i,
    input  logic                       phy_rx_valid
);
    localparam int LW = $clog2(2 * LATENCY + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam int RW = $clog2(TCSHI + 1);
    localparam logic [LW-1:0] LAT_1X   = LW'(LATENCY - 1);
    localparam logic [LW-1:0] LAT_2X   = LW'(2 * LATENCY - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(RD_TIMEOUT - 1);
    localparam logic [RW-1:0] REC_LAST = RW'(TCSHI - 1);

    typedef enum logic [2:0] {IDLE, CA0, CA1, CA2, LAT, WDATA, RDATA, RECOV} state_t;

    state_t              state;
    logic [31:0]         wa;
    logic [47:0]         ca;
    logic [31:0]         ca_lo;
    logic [15:0]         wdat;
    logic [1:0]          wmask;
    logic                is_rd;
    logic                dbl;
    logic [LW-1:0]       lat_cnt;
    logic [TW-1:0]       to_cnt;
    logic [RW-1:0]       rec_cnt;

    // Command-address from the live request; write wins when both are raised.
    always_comb begin
        wa = 32'(hbus_adr_i >> 1);
        ca = {~hbus_wrq, 1'b0, 1'b1, wa[31:3], 13'd0, wa[2:0]};
    end

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge hbus_clk) begin
        if (hbus_rst) begin
            state       <= IDLE;
            hbus_ready  <= 1'b0;
            hbus_valid  <= 1'b0;
            hbus_err    <= 1'b0;
            hbus_dat_o  <= '0;
            phy_cs_n    <= 1'b1;
            phy_ck_en   <= 1'b0;
            phy_dq_o    <= '0;
            phy_dq_oe   <= 1'b0;
            phy_rwds_o  <= '0;
            phy_rwds_oe <= 1'b0;
            ca_lo       <= '0;
            wdat        <= '0;
            wmask       <= '0;
            is_rd       <= 1'b0;
            dbl         <= 1'b0;
            lat_cnt     <= '0;
            to_cnt      <= '0;
            rec_cnt     <= '0;
        end else begin
            hbus_valid <= 1'b0;
            hbus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    hbus_ready <= 1'b1;
                    if (hbus_ready && (hbus_rrq || hbus_wrq)) begin
                        hbus_ready <= 1'b0;
                        is_rd      <= ~hbus_wrq;
                        ca_lo      <= ca[31:0];
                        wdat       <= hbus_dat_i;
                        wmask      <= hbus_mask_i;
                        phy_dq_o   <= ca[47:32];
                        phy_dq_oe  <= 1'b1;
                        phy_cs_n   <= 1'b0;
                        phy_ck_en  <= 1'b1;
                        state      <= CA0;
                    end
                end
                CA0: begin
                    // device requests 2x latency by driving RWDS high during CA
                    dbl      <= (FIXED_LATENCY != 0) || phy_rwds_i;
                    phy_dq_o <= ca_lo[31:16];
                    state    <= CA1;
                end
                CA1: begin
                    phy_dq_o <= ca_lo[15:0];
                    state    <= CA2;
                end
                CA2: begin
                    phy_dq_o  <= '0;
                    phy_dq_oe <= 1'b0;
                    lat_cnt   <= dbl ? LAT_2X : LAT_1X;
                    state     <= LAT;
                end
                LAT: begin
                    if (lat_cnt == '0) begin
                        if (is_rd) begin
                            to_cnt <= '0;
                            state  <= RDATA;
                        end else begin
                            phy_dq_o    <= wdat;
                            phy_dq_oe   <= 1'b1;
                            phy_rwds_o  <= wmask;
                            phy_rwds_oe <= 1'b1;
                            state       <= WDATA;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                WDATA: begin
                    phy_cs_n    <= 1'b1;
                    phy_ck_en   <= 1'b0;
                    phy_dq_o    <= '0;
                    phy_dq_oe   <= 1'b0;
                    phy_rwds_o  <= '0;
                    phy_rwds_oe <= 1'b0;
                    rec_cnt     <= REC_LAST;
                    state       <= RECOV;
                end
                RDATA: begin
                    if (phy_rx_valid || to_cnt == TO_LAST) begin
                        // a timeout returns zero data flagged with hbus_err
                        hbus_dat_o <= phy_rx_valid ? phy_dq_i : '0;
                        hbus_valid <= 1'b1;
                        hbus_err   <= ~phy_rx_valid;
                        phy_cs_n   <= 1'b1;
                        phy_ck_en  <= 1'b0;
                        rec_cnt    <= REC_LAST;
                        state      <= RECOV;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RECOV: begin
                    if (rec_cnt == '0) begin
                        hbus_ready <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        rec_cnt <= rec_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Bench for hyperbus_ctrl: two instances (variable and fixed 2x latency)
// share one stimulus stream; a schedule-based reference predicts every
// output each cycle, and directed literal checks pin key values.
module tb_hyperbus_ctrl;
    localparam int LAT_T  = 6;
    localparam int TCS_T  = 2;
    localparam int RDTO_T = 64;

    typedef struct packed {
        logic        cs_n;
        logic        ck_en;
        logic [15:0] dq_o;
        logic        dq_oe;
        logic [1:0]  rwds_o;
        logic        rwds_oe;
        logic        ready;
        logic        valid;
        logic        err;
        logic [15:0] dat_o;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [15:0] dat = '0;
    logic [15:0] dq_i = '0;
    logic [1:0]  mask = '0;
    logic        rrq = 1'b0, wrq = 1'b0, rwds_i = 1'b0, rx_valid = 1'b0;

    logic        rdy[2], vld[2], err[2], csn[2], cke[2], dqoe[2], rwoe[2];
    logic [15:0] dqo[2], dato[2];
    logic [1:0]  rwo[2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hyperbus_ctrl #(.FIXED_LATENCY(0)) u0 (
        .hbus_clk(clk), .hbus_rst(rst), .hbus_adr_i(adr), .hbus_dat_i(dat),
        .hbus_mask_i(mask), .hbus_rrq(rrq), .hbus_wrq(wrq),
        .hbus_ready(rdy[0]), .hbus_valid(vld[0]), .hbus_dat_o(dato[0]), .hbus_err(err[0]),
        .phy_cs_n(csn[0]), .phy_ck_en(cke[0]), .phy_dq_o(dqo[0]), .phy_dq_oe(dqoe[0]),
        .phy_rwds_o(rwo[0]), .phy_rwds_oe(rwoe[0]), .phy_dq_i(dq_i),
        .phy_rwds_i(rwds_i), .phy_rx_valid(rx_valid)
    );

    hyperbus_ctrl #(.FIXED_LATENCY(1)) u1 (
        .hbus_clk(clk), .hbus_rst(rst), .hbus_adr_i(adr), .hbus_dat_i(dat),
        .hbus_mask_i(mask), .hbus_rrq(rrq), .hbus_wrq(wrq),
        .hbus_ready(rdy[1]), .hbus_valid(vld[1]), .hbus_dat_o(dato[1]), .hbus_err(err[1]),
        .phy_cs_n(csn[1]), .phy_ck_en(cke[1]), .phy_dq_o(dqo[1]), .phy_dq_oe(dqoe[1]),
        .phy_rwds_o(rwo[1]), .phy_rwds_oe(rwoe[1]), .phy_dq_i(dq_i),
        .phy_rwds_i(rwds_i), .phy_rx_valid(rx_valid)
    );

    function automatic obs_t mk(logic cs_n, logic ck_en, logic [15:0] dq, logic dq_oe,
                                logic [1:0] rw, logic rw_oe, logic ready, logic valid,
                                logic e, logic [15:0] d);
        obs_t r;
        r.cs_n = cs_n; r.ck_en = ck_en; r.dq_o = dq; r.dq_oe = dq_oe;
        r.rwds_o = rw; r.rwds_oe = rw_oe; r.ready = ready; r.valid = valid;
        r.err = e; r.dat_o = d;
        return r;
    endfunction

    // ---------------- reference model ----------------
    int          phase[2], slen[2], spos[2], rcnt[2];
    logic        m_wait[2], m_rd[2];
    logic [47:0] m_ca[2];
    logic [15:0] m_wd[2], m_dat[2];
    logic [1:0]  m_mk[2];
    obs_t        exp_o[2];
    obs_t        sched[2][64];
    bit          mvalid = 1'b0;
    logic [47:0] wa48;
    int          nlat;

    task automatic push(int k, obs_t r);
        sched[k][slen[k]] = r;
        slen[k] = slen[k] + 1;
    endtask

    function automatic obs_t idle_o(int k);
        return mk(1'b1, 1'b0, 16'h0, 1'b0, 2'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_dat[k]);
    endfunction
    function automatic obs_t busy_o(int k);
        return mk(1'b0, 1'b1, 16'h0, 1'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_dat[k]);
    endfunction
    function automatic obs_t ca_o(int k, logic [15:0] w);
        return mk(1'b0, 1'b1, w, 1'b1, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_dat[k]);
    endfunction
    function automatic obs_t rec_o(int k, logic v, logic e);
        return mk(1'b1, 1'b0, 16'h0, 1'b0, 2'b0, 1'b0, 1'b0, v, e, m_dat[k]);
    endfunction

    // Predict the next cycle's outputs of both instances.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                phase[k] = 0;
                m_dat[k] = 16'h0;
                exp_o[k] = mk(1'b1, 1'b0, 16'h0, 1'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
            end else begin
                case (phase[k])
                    0: if (exp_o[k].ready && (rrq || wrq)) begin
                        m_rd[k] = !wrq;
                        m_wd[k] = dat;
                        m_mk[k] = mask;
                        wa48    = 48'(adr) / 2;
                        m_ca[k] = {m_rd[k], 47'd0} | (48'd1 << 45) | ((wa48 / 8) << 16) | (wa48 % 8);
                        exp_o[k] = ca_o(k, m_ca[k][47:32]);
                        phase[k] = 1;
                    end else begin
                        exp_o[k] = idle_o(k);
                    end
                    1: begin
                        nlat = ((k == 1) || rwds_i) ? 2 * LAT_T : LAT_T;
                        slen[k] = 0;
                        push(k, ca_o(k, m_ca[k][31:16]));
                        push(k, ca_o(k, m_ca[k][15:0]));
                        for (int i = 0; i < nlat; i++) push(k, busy_o(k));
                        if (!m_rd[k]) begin
                            push(k, mk(1'b0, 1'b1, m_wd[k], 1'b1, m_mk[k], 1'b1, 1'b0, 1'b0, 1'b0, m_dat[k]));
                            for (int i = 0; i < TCS_T; i++) push(k, rec_o(k, 1'b0, 1'b0));
                        end
                        m_wait[k] = m_rd[k];
                        exp_o[k] = sched[k][0];
                        spos[k] = 1;
                        phase[k] = 2;
                    end
                    2: if (spos[k] < slen[k]) begin
                        exp_o[k] = sched[k][spos[k]];
                        spos[k] = spos[k] + 1;
                    end else if (m_wait[k]) begin
                        m_wait[k] = 1'b0;
                        rcnt[k] = 0;
                        exp_o[k] = busy_o(k);
                        phase[k] = 3;
                    end else begin
                        exp_o[k] = idle_o(k);
                        phase[k] = 0;
                    end
                    default: begin
                        rcnt[k] = rcnt[k] + 1;
                        if (rx_valid || rcnt[k] == RDTO_T) begin
                            m_dat[k] = rx_valid ? dq_i : 16'h0;
                            slen[k] = 0;
                            push(k, rec_o(k, 1'b1, !rx_valid));
                            for (int i = 1; i < TCS_T; i++) push(k, rec_o(k, 1'b0, 1'b0));
                            exp_o[k] = sched[k][0];
                            spos[k] = 1;
                            phase[k] = 2;
                        end else begin
                            exp_o[k] = busy_o(k);
                        end
                    end
                endcase
            end
        end
        mvalid = 1'b1;
    end

    // Every-cycle comparison of both instances against the reference.
    always @(negedge clk) begin
        obs_t a;
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                a = mk(csn[k], cke[k], dqo[k], dqoe[k], rwo[k], rwoe[k], rdy[k], vld[k], err[k], dato[k]);
                total++;
                if (a !== exp_o[k]) begin
                    bad++;
                    $display("FAIL cycle_u%0d t=%0t got=%h want=%h", k, $time, a, exp_o[k]);
                end
            end
        end
    end

    task automatic chk1(string nm, logic got, logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic chk16(string nm, logic [15:0] got, logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(rdy[0] && rdy[1]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(rdy[0] && rdy[1])) begin
            bad++;
            $display("FAIL ready_timeout got=%b%b want=11", rdy[1], rdy[0]);
        end
    endtask

    initial begin
        int lat;
        // reset
        repeat (3) @(negedge clk);
        chk1("rst_csn", csn[0], 1'b1);
        chk1("rst_dqoe", dqoe[0], 1'b0);
        chk1("rst_rwoe", rwoe[0], 1'b0);
        chk1("rst_rdy", rdy[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("rdy_after_rst_u0", rdy[0], 1'b1);
        chk1("rdy_after_rst_u1", rdy[1], 1'b1);

        // write 0x1234 <= 0xA55A, mask 01
        wait_ready();
        adr = 32'h1234; dat = 16'hA55A; mask = 2'b01; wrq = 1'b1; rwds_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin wrq = 1'b0; chk16("w_ca0", dqo[1], 16'h2000); end
            if (k == 2) chk16("w_ca1", dqo[1], 16'h0123);
            if (k == 3) chk16("w_ca2", dqo[1], 16'h0002);
            if (k >= 4 && !csn[1] && !dqoe[1]) lat++;
            if (k == 16) begin
                chk16("w_data", dqo[1], 16'hA55A);
                chk16("w_mask", {14'd0, rwo[1]}, 16'h0001);
                chk1("w_rwoe", rwoe[1], 1'b1);
            end
            if (k == 18) begin chk1("w_rec_csn", csn[1], 1'b1); chk1("w_rec_rdy", rdy[1], 1'b0); end
            if (k == 19) chk1("w_rdy_back", rdy[1], 1'b1);
        end
        chk16("w_lat", 16'(lat), 16'd12);

        // read 0x10, 1x latency on u0; u1 sees the rx pulse in LAT and times out
        wait_ready();
        adr = 32'h10; rrq = 1'b1; rwds_i = 1'b0; dq_i = 16'hBEEF;
        for (int k = 1; k <= 85; k++) begin
            @(negedge clk);
            if (k == 1) begin rrq = 1'b0; chk16("r_ca0", dqo[0], 16'hA000); end
            if (k == 3) chk16("r_ca2", dqo[0], 16'h0000);
            if (k == 13) begin
                chk1("r_valid", vld[0], 1'b1);
                chk16("r_data", dato[0], 16'hBEEF);
                chk1("r_noerr", err[0], 1'b0);
            end
            if (k == 79) chk1("to_early", vld[1], 1'b0);
            if (k == 80) begin
                chk1("to_valid", vld[1], 1'b1);
                chk1("to_err", err[1], 1'b1);
                chk16("to_data", dato[1], 16'h0000);
            end
            rx_valid = (k == 12);
        end

        // read with RWDS high in CA0: 2x latency, rx_valid held from the start
        wait_ready();
        adr = 32'h10; rrq = 1'b1; rwds_i = 1'b1; rx_valid = 1'b1; dq_i = 16'h1234;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) rrq = 1'b0;
            if (k == 2) rwds_i = 1'b0;
            if (k == 16) chk1("r2x_early", vld[0], 1'b0);
            if (k == 17) begin chk1("r2x_valid", vld[0], 1'b1); chk16("r2x_data", dato[0], 16'h1234); end
        end
        rx_valid = 1'b0;

        // both requests -> write; read held through RECOV waits for ready
        wait_ready();
        adr = 32'h20; rrq = 1'b1; wrq = 1'b1; rwds_i = 1'b1; dat = 16'h0F0F; mask = 2'b10;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin rrq = 1'b0; wrq = 1'b0; chk16("both_is_write", dqo[0], 16'h2000); end
            if (k == 17) rrq = 1'b1;
            if (k == 18) chk1("held_not_taken", csn[0], 1'b1);
            if (k == 19) begin chk1("held_csn", csn[0], 1'b1); chk1("held_rdy", rdy[0], 1'b1); end
            if (k == 20) begin
                rrq = 1'b0; rx_valid = 1'b1; dq_i = 16'h5A5A;
                chk16("held_ca0", dqo[0], 16'hA000);
            end
            if (k == 36) begin chk1("held_valid", vld[0], 1'b1); chk16("held_data", dato[0], 16'h5A5A); end
        end
        rx_valid = 1'b0; rwds_i = 1'b0;

        // reset in the middle of LAT, then a fresh read
        wait_ready();
        adr = 32'h40; rrq = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) rrq = 1'b0;
            if (k == 6) rst = 1'b1;
            if (k == 7) begin
                chk1("mid_rst_csn", csn[0], 1'b1);
                chk1("mid_rst_cke", cke[0], 1'b0);
                chk1("mid_rst_rdy", rdy[0], 1'b0);
                rst = 1'b0;
            end
            if (k == 8) chk1("post_rst_rdy", rdy[0], 1'b1);
        end
        wait_ready();
        rrq = 1'b1; rx_valid = 1'b1; dq_i = 16'hC0DE;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) rrq = 1'b0;
            if (k == 11) begin chk1("pr_valid", vld[0], 1'b1); chk16("pr_data", dato[0], 16'hC0DE); end
            if (k == 17) chk1("pr_valid_u1", vld[1], 1'b1);
        end
        rx_valid = 1'b0;
        wait_ready();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
